// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorting network for N = 2^LOG2N unsigned elements.
// Every comparator layer is followed by one register layer (data, valid, desc),
// so latency is LOG2N*(LOG2N+1)/2 cycles at one vector per cycle. A stalled
// output (out_valid && !out_ready) freezes the whole pipe, bubbles included.
module bitonic_sort_pipe #(
    parameter int DATA_W = 8,
    parameter int LOG2N  = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_desc,
    input  logic [(DATA_W << LOG2N)-1:0]      in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_desc,
    output logic [(DATA_W << LOG2N)-1:0]      out_data
);

    localparam int N  = 1 << LOG2N;
    localparam int VW = N * DATA_W;
    localparam int NL = LOG2N * (LOG2N + 1) / 2;

    // One comparator layer: stage s, sub-step j. Pairs (i, i^2^j) with bit j of
    // i clear; bit s of i selects descending, and desc inverts every pair.
    // Equal elements are never swapped.
    function automatic logic [VW-1:0] cmp_layer(
        input logic [VW-1:0] x,
        input int            s,
        input int            j,
        input logic          desc
    );
        logic [VW-1:0]     y;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              dir;
        y = x;
        for (int i = 0; i < N; i++) begin
            if (((i >> j) & 1) == 0) begin
                a   = x[i*DATA_W +: DATA_W];
                b   = x[(i + (1 << j))*DATA_W +: DATA_W];
                dir = (((i >> s) & 1) != 0) ^ desc;
                if (dir ? (a < b) : (a > b)) begin
                    y[i*DATA_W +: DATA_W]              = b;
                    y[(i + (1 << j))*DATA_W +: DATA_W] = a;
                end
            end
        end
        return y;
    endfunction

    logic [VW-1:0] data_q    [NL];
    logic [NL-1:0] valid_q;
    logic [NL-1:0] desc_q;

    logic [VW-1:0] src_data  [NL];
    logic [NL-1:0] src_valid;
    logic [NL-1:0] src_desc;
    logic [VW-1:0] layer_out [NL];
    logic          stall;

    assign stall    = valid_q[NL-1] && !out_ready;
    assign in_ready = !stall;

    assign out_valid = valid_q[NL-1];
    assign out_desc  = desc_q[NL-1];
    assign out_data  = data_q[NL-1];

    // Layer inputs: layer 0 takes the port, every later layer its predecessor's register.
    always_comb begin
        src_data     = '{default: '0};
        src_valid    = '0;
        src_desc     = '0;
        src_data[0]  = in_data;
        src_valid[0] = in_valid;
        src_desc[0]  = in_desc;
        for (int l = 1; l < NL; l++) begin
            src_data[l]  = data_q[l-1];
            src_valid[l] = valid_q[l-1];
            src_desc[l]  = desc_q[l-1];
        end
    end

    // Comparator network: walk stages s and sub-steps j = s-1..0 in layer order.
    always_comb begin
        int l;
        layer_out = '{default: '0};
        l = 0;
        for (int s = 1; s <= LOG2N; s++) begin
            for (int k = 0; k < s; k++) begin
                layer_out[l] = cmp_layer(src_data[l], s, s - 1 - k, src_desc[l]);
                l = l + 1;
            end
        end
    end

    // Pipeline registers: clear on reset, hold on stall, otherwise every layer advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < NL; l++) begin
                data_q[l] <= '0;
            end
            valid_q <= '0;
            desc_q  <= '0;
        end else if (!stall) begin
            for (int l = 0; l < NL; l++) begin
                data_q[l] <= layer_out[l];
            end
            valid_q <= src_valid;
            desc_q  <= src_desc;
        end
    end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Bench for bitonic_sort_pipe: default instance (8-bit x 8) plus two sweep
// instances (1-bit x 2, 16-bit x 16). A plain sort model feeds per-instance
// scoreboards that are checked on every cycle an output is present.
module tb_bitonic_sort_pipe;

    localparam int NL0 = 6;
    localparam int NL1 = 1;
    localparam int NL2 = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    // default instance
    logic        v0, r0, d0, ov0, or0, od0;
    logic [63:0] din0, dout0;
    // 1-bit x 2 instance
    logic        v1, r1, d1, ov1, or1, od1;
    logic [1:0]  din1, dout1;
    // 16-bit x 16 instance
    logic         v2, r2, d2, ov2, or2, od2;
    logic [255:0] din2, dout2;

    bitonic_sort_pipe #(.DATA_W(8), .LOG2N(3)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_desc(d0), .in_data(din0),
        .out_valid(ov0), .out_ready(or0), .out_desc(od0), .out_data(dout0));

    bitonic_sort_pipe #(.DATA_W(1), .LOG2N(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_desc(d1), .in_data(din1),
        .out_valid(ov1), .out_ready(or1), .out_desc(od1), .out_data(dout1));

    bitonic_sort_pipe #(.DATA_W(16), .LOG2N(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_desc(d2), .in_data(din2),
        .out_valid(ov2), .out_ready(or2), .out_desc(od2), .out_data(dout2));

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: extract n elements of w bits, sort by value, repack.
    function automatic logic [255:0] ref_sort(input logic [255:0] x, input int n, input int w, input bit desc);
        longint unsigned v[16];
        longint unsigned t;
        longint unsigned mask;
        logic [255:0]    r;
        mask = (64'd1 << w) - 64'd1;
        for (int k = 0; k < n; k++) v[k] = 64'(x >> (k * w)) & mask;
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                if (v[b] < v[a]) begin t = v[a]; v[a] = v[b]; v[b] = t; end
        r = '0;
        for (int k = 0; k < n; k++) r = r | (256'(v[desc ? n - 1 - k : k]) << (k * w));
        return r;
    endfunction

    // scoreboard for the default instance: ordering, data, desc, stall hold, handshake rule
    logic [64:0]  q0[$];
    logic [64:0]  prev0;
    logic [255:0] tmp0;
    int           dcnt0 = 0;
    bit           rst_d = 1'b0;
    bit           stall_d = 1'b0;
    always @(negedge clk) begin
        if (rst_d) begin
            check("reset_out_valid", 256'(ov0), 256'(0));
            check("reset_out_data", 256'(dout0), 256'(0));
            check("reset_out_desc", 256'(od0), 256'(0));
        end
        if (rst) begin
            q0.delete();
        end else begin
            check("in_ready_rule", 256'(r0), 256'(!(ov0 && !or0)));
            if (stall_d) check("stall_hold", 256'({od0, dout0}), 256'(prev0));
            if (ov0) begin
                if (q0.size() == 0) begin
                    check("unexpected_out", 256'(ov0), 256'(0));
                end else begin
                    check("sorted_out", 256'({od0, dout0}), 256'(q0[0]));
                    if (or0) begin
                        void'(q0.pop_front());
                        dcnt0++;
                    end
                end
            end
            if (v0 && r0) begin
                tmp0 = ref_sort(256'(din0), 8, 8, d0);
                q0.push_back({d0, tmp0[63:0]});
            end
        end
        rst_d   = rst;
        stall_d = ov0 && !or0 && !rst;
        prev0   = {od0, dout0};
    end

    // scoreboards for the sweep instances, including exact latency
    logic [288:0] q1[$], q2[$];
    logic [288:0] e1, e2;
    logic [255:0] tmp1, tmp2;
    int           dcnt1 = 0;
    int           dcnt2 = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (ov1) begin
                if (q1.size() == 0) check("s1_unexpected", 256'(ov1), 256'(0));
                else begin
                    e1 = q1.pop_front();
                    check("s1_data", 256'(dout1), e1[255:0]);
                    check("s1_desc", 256'(od1), 256'(e1[256]));
                    check("s1_latency", 256'(cyc - int'(e1[288:257])), 256'(NL1));
                    dcnt1++;
                end
            end
            if (v1 && r1) begin
                tmp1 = ref_sort(256'(din1), 2, 1, d1);
                q1.push_back({32'(cyc), d1, tmp1});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ov2) begin
                if (q2.size() == 0) check("s2_unexpected", 256'(ov2), 256'(0));
                else begin
                    e2 = q2.pop_front();
                    check("s2_data", dout2, e2[255:0]);
                    check("s2_desc", 256'(od2), 256'(e2[256]));
                    check("s2_latency", 256'(cyc - int'(e2[288:257])), 256'(NL2));
                    dcnt2++;
                end
            end
            if (v2 && r2) begin
                tmp2 = ref_sort(din2, 16, 16, d2);
                q2.push_back({32'(cyc), d2, tmp2});
            end
        end
    end

    task automatic directed(input logic [63:0] x, input logic desc, input logic [63:0] exp, input string nm);
        int n;
        v0 = 1'b1; din0 = x; d0 = desc;
        @(posedge clk); #1;
        v0 = 1'b0;
        n = 0;
        while (!ov0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, 256'(n), 256'(NL0 - 1));
        check({nm, "_data"}, 256'(dout0), 256'(exp));
        check({nm, "_desc"}, 256'(od0), 256'(desc));
        @(posedge clk); #1;
        check({nm, "_single_beat"}, 256'(ov0), 256'(0));
    endtask

    function automatic logic [255:0] mk2(input int i);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            case (i)
                0: r[k*16 +: 16] = 16'h1234;
                1: r[k*16 +: 16] = 16'hFFFF;
                2: r[k*16 +: 16] = 16'(k);
                3: r[k*16 +: 16] = 16'(15 - k);
                4: r[k*16 +: 16] = (k % 3 == 0) ? 16'hFFFF : 16'h0000;
                default: r[k*16 +: 16] = 16'($urandom);
            endcase
        end
        return r;
    endfunction

    int           base;
    int           bp_k, bp_guard, bp_n;
    logic         bp_acc;
    logic [255:0] pin;
    logic [1:0]   s1_vec[8];

    initial begin
        v0 = 1'b1; d0 = 1'b1; din0 = 64'hDEAD_BEEF_0123_4567; or0 = 1'b1;
        v1 = 1'b0; d1 = 1'b0; din1 = '0; or1 = 1'b1;
        v2 = 1'b0; d2 = 1'b0; din2 = '0; or2 = 1'b1;
        rst = 1'b1;

        // reset with input pending, then idle: nothing may emerge
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; v0 = 1'b0;
        check("in_ready_after_reset", 256'(r0), 256'(1));
        repeat (NL0 + 2) @(posedge clk);
        #1;

        // model pins
        pin = ref_sort(256'(64'h0109_03FF_00C8_0307), 8, 8, 1'b0);
        check("model_pin_asc", pin, 256'(64'hFFC8_0907_0303_0100));
        pin = ref_sort(256'(64'h0109_03FF_00C8_0307), 8, 8, 1'b1);
        check("model_pin_desc", pin, 256'(64'h0001_0303_0709_C8FF));
        pin = ref_sort(256'(2'b01), 2, 1, 1'b0);
        check("model_pin_w1", pin, 256'(2'b10));

        directed(64'h0109_03FF_00C8_0307, 1'b0, 64'hFFC8_0907_0303_0100, "asc");
        directed(64'h0109_03FF_00C8_0307, 1'b1, 64'h0001_0303_0709_C8FF, "desc");
        directed(64'h0102_0304_0506_0708, 1'b0, 64'h0807_0605_0403_0201, "reverse_in");
        directed(64'h5A5A_5A5A_5A5A_5A5A, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A, "all_equal");
        directed(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "all_ones");

        // back-to-back streaming, alternating direction
        base = dcnt0;
        for (int i = 0; i < 20; i++) begin
            v0 = 1'b1; d0 = i[0]; din0 = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        v0 = 1'b0;
        repeat (NL0 + 2) @(posedge clk);
        #1;
        check("stream_count", 256'(dcnt0 - base), 256'(20));

        // backpressure: consumer stalls 4 cycles once output appears
        base = dcnt0;
        fork
            begin
                bp_k = 0; bp_guard = 0;
                v0 = 1'b1; d0 = 1'($urandom); din0 = {$urandom, $urandom};
                while (bp_k < 10 && bp_guard < 200) begin
                    @(negedge clk);
                    bp_acc = r0;
                    @(posedge clk); #1;
                    if (bp_acc) begin
                        bp_k++;
                        if (bp_k < 10) begin
                            d0 = 1'($urandom); din0 = {$urandom, $urandom};
                        end else begin
                            v0 = 1'b0;
                        end
                    end
                    bp_guard++;
                end
                v0 = 1'b0;
                check("bp_all_sent", 256'(bp_k), 256'(10));
            end
            begin
                bp_n = 0;
                while (!ov0 && bp_n < 50) begin
                    @(posedge clk); #1;
                    bp_n++;
                end
                check("bp_saw_valid", 256'(ov0), 256'(1));
                or0 = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 256'(r0), 256'(0));
                    @(posedge clk); #1;
                end
                or0 = 1'b1;
            end
        join
        repeat (NL0 + 6) @(posedge clk);
        #1;
        check("bp_count", 256'(dcnt0 - base), 256'(10));

        // reset mid-flight discards everything
        base = dcnt0;
        for (int i = 0; i < 3; i++) begin
            v0 = 1'b1; d0 = 1'b0; din0 = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; v0 = 1'b0;
        check("in_ready_after_midreset", 256'(r0), 256'(1));
        repeat (NL0 + 3) @(posedge clk);
        #1;
        check("midreset_flush_count", 256'(dcnt0 - base), 256'(0));

        // parametric sweep instances
        s1_vec[0] = 2'b00; s1_vec[1] = 2'b11; s1_vec[2] = 2'b01; s1_vec[3] = 2'b10;
        s1_vec[4] = 2'b01; s1_vec[5] = 2'b10; s1_vec[6] = 2'b11; s1_vec[7] = 2'b01;
        for (int i = 0; i < 8; i++) begin
            v1 = 1'b1; d1 = i[0];  din1 = s1_vec[i];
            v2 = 1'b1; d2 = ~i[1]; din2 = mk2(i);
            @(posedge clk); #1;
        end
        v1 = 1'b0; v2 = 1'b0;
        repeat (NL2 + 3) @(posedge clk);
        #1;
        check("s1_count", 256'(dcnt1), 256'(8));
        check("s2_count", 256'(dcnt2), 256'(8));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
